// File: rtl/regfile_write_decoder_if.sv
// Write-back bus between the WB stage and the register file, plus the flat register export.
// Latency: none; this file only groups signals.
// Backpressure: none; every write is accepted on the cycle it is presented.
interface regfile_write_decoder_if #(
    parameter int WIDTH     = 64,
    parameter int ADDR_BITS = 5
);
    localparam int NUM_REGS = 1 << ADDR_BITS;

    // Write request from the WB stage
    logic                      wr_en;
    logic [ADDR_BITS-1:0]      wr_addr;
    logic [WIDTH-1:0]          wr_data;

    // Decoder and storage outputs
    logic [NUM_REGS-1:0]       dec_en;
    logic [NUM_REGS*WIDTH-1:0] regs_flat;

    // WB stage / testbench side
    modport master (
        output wr_en,
        output wr_addr,
        output wr_data,
        input  dec_en,
        input  regs_flat
    );

    // Register file side
    modport slave (
        input  wr_en,
        input  wr_addr,
        input  wr_data,
        output dec_en,
        output regs_flat
    );
endinterface

// File: rtl/regfile_write_decoder.sv
// Register file write side: decodes the write address to one-hot enables and owns the storage.
// Latency: dec_en is combinational; a written value appears on regs_flat one clock after sampling.
// Backpressure: none; one write per cycle is always accepted, and writes to ZERO_REG are dropped.
module regfile_write_decoder #(
    parameter int WIDTH     = 64,
    parameter int ADDR_BITS = 5,
    parameter int ZERO_REG  = 31
) (
    input  logic                          clk,
    input  logic                          reset,
    regfile_write_decoder_if.slave        i_wb
);
    localparam int NUM_REGS = 1 << ADDR_BITS;
    // The decoder is split into a low 2:4 stage and a high stage (3:8 for ADDR_BITS=5).
    localparam int LO_BITS  = 2;
    localparam int HI_BITS  = ADDR_BITS - LO_BITS;
    localparam int LO_N     = 1 << LO_BITS;
    localparam int HI_N     = 1 << HI_BITS;

    logic [LO_N-1:0]     w_lo_dec;
    logic [HI_N-1:0]     w_hi_dec;
    logic [NUM_REGS-1:0] w_dec_raw;
    logic [NUM_REGS-1:0] w_zero_mask;
    logic [NUM_REGS-1:0] w_dec_en;
    logic [WIDTH-1:0]    w_reg_q [NUM_REGS];
    logic [NUM_REGS*WIDTH-1:0] w_regs_flat;

    // Low 2:4 predecode of the two least significant address bits
    always_comb begin
        w_lo_dec = '0;
        for (int j = 0; j < LO_N; j++) begin
            w_lo_dec[j] = (i_wb.wr_addr[LO_BITS-1:0] == LO_BITS'(j));
        end
    end

    // High predecode of the remaining address bits, gated by wr_en so that an
    // unknown address with wr_en low still yields all-zero enables
    always_comb begin
        w_hi_dec = '0;
        for (int j = 0; j < HI_N; j++) begin
            w_hi_dec[j] = i_wb.wr_en & (i_wb.wr_addr[ADDR_BITS-1:LO_BITS] == HI_BITS'(j));
        end
    end

    // Final AND plane: enable k is the product of its high and low predecode lines,
    // with the hardwired-zero entry masked off
    genvar k;
    generate
        for (k = 0; k < NUM_REGS; k++) begin : g_dec
            assign w_dec_raw[k]   = w_hi_dec[k / LO_N] & w_lo_dec[k % LO_N];
            assign w_zero_mask[k] = (k == ZERO_REG);
        end
    endgenerate

    assign w_dec_en    = w_dec_raw & ~w_zero_mask;
    assign i_wb.dec_en = w_dec_en;

    // Storage: one register per writable entry, loaded through a 2:1 feedback mux
    generate
        for (k = 0; k < NUM_REGS; k++) begin : g_reg
            if (k == ZERO_REG) begin : g_zero
                // XZR has no flops; it always reads zero
                assign w_reg_q[k] = '0;
            end else begin : g_flop
                logic [WIDTH-1:0] r_q;
                logic [WIDTH-1:0] w_d;

                // Feedback mux: take write data when enabled, otherwise hold
                assign w_d = w_dec_en[k] ? i_wb.wr_data : r_q;

                // Register update; reset takes priority over a same-cycle write
                always_ff @(posedge clk) begin
                    if (reset) begin
                        r_q <= '0;
                    end else begin
                        r_q <= w_d;
                    end
                end

                assign w_reg_q[k] = r_q;
            end
        end
    endgenerate

    // Flatten the array for the external read-mux trees; reg k sits at [k*WIDTH +: WIDTH]
    generate
        for (k = 0; k < NUM_REGS; k++) begin : g_flat
            assign w_regs_flat[k*WIDTH +: WIDTH] = w_reg_q[k];
        end
    endgenerate

    assign i_wb.regs_flat = w_regs_flat;

endmodule

// File: tb/tb_regfile_write_decoder.sv
// Self-checking bench for regfile_write_decoder against an array-based reference model.
// Latency: checks dec_en within the write cycle and register contents one edge later.
// Backpressure: none; one operation is driven per clock.
module tb_regfile_write_decoder;
    localparam int WIDTH     = 64;
    localparam int ADDR_BITS = 5;
    localparam int NUM_REGS  = 32;
    localparam int ZERO_REG  = 31;

    logic clk;
    logic reset;

    regfile_write_decoder_if #(.WIDTH(WIDTH), .ADDR_BITS(ADDR_BITS)) wb_bus ();

    regfile_write_decoder #(
        .WIDTH     (WIDTH),
        .ADDR_BITS (ADDR_BITS),
        .ZERO_REG  (ZERO_REG)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .i_wb  (wb_bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain array of register contents
    logic [WIDTH-1:0] model [NUM_REGS];

    int total_cnt = 0;
    int bad_cnt   = 0;

    task automatic check_val(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] reg_of(input int idx);
        logic [NUM_REGS*WIDTH-1:0] flat;
        flat = wb_bus.regs_flat;
        return flat[idx*WIDTH +: WIDTH];
    endfunction

    task automatic check_all_regs(input string tag);
        for (int i = 0; i < NUM_REGS; i++) begin
            check_val($sformatf("%s_r%0d", tag, i), reg_of(i), model[i]);
        end
    endtask

    // One clock of stimulus. Entered and left at posedge+1.
    task automatic step(input logic rst, input logic en, input logic [ADDR_BITS-1:0] addr,
                        input logic [WIDTH-1:0] data, input string tag);
        logic [NUM_REGS-1:0] exp_dec;
        reset          = rst;
        wb_bus.wr_en   = en;
        wb_bus.wr_addr = addr;
        wb_bus.wr_data = data;
        #1;
        // Decoder output is combinational and ignores reset
        exp_dec = '0;
        if (en && (int'(addr) != ZERO_REG)) exp_dec[addr] = 1'b1;
        check_val({tag, "_dec"}, WIDTH'(wb_bus.dec_en), WIDTH'(exp_dec));
        // Storage must still show pre-write contents during the write cycle
        check_all_regs({tag, "_pre"});
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
        end else if (en && (int'(addr) != ZERO_REG)) begin
            model[addr] = data;
        end
        #1;
        check_all_regs({tag, "_post"});
    endtask

    initial begin
        for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
        reset          = 1'b1;
        wb_bus.wr_en   = 1'b0;
        wb_bus.wr_addr = '0;
        wb_bus.wr_data = '0;
        @(posedge clk);
        #1;

        // 1: reset clears everything, dec_en idle
        step(1'b1, 1'b0, 5'd0, '0, "rst");
        step(1'b0, 1'b0, 5'd3, 64'h1234, "idle");

        // 2: single write to reg5
        step(1'b0, 1'b1, 5'd5, 64'hDEAD_BEEF_0000_0005, "wr5");

        // 3: write to XZR is dropped
        step(1'b0, 1'b1, 5'd31, {WIDTH{1'b1}}, "wr31");
        check_val("xzr_zero", reg_of(ZERO_REG), '0);

        // 4: back-to-back writes, last one wins
        step(1'b0, 1'b1, 5'd0,  64'd1, "b2b_a");
        step(1'b0, 1'b1, 5'd30, 64'd2, "b2b_b");
        step(1'b0, 1'b1, 5'd0,  64'd3, "b2b_c");
        check_val("b2b_r0",  reg_of(0),  64'd3);
        check_val("b2b_r30", reg_of(30), 64'd2);

        // 5: reset beats a same-cycle write, next write commits
        step(1'b1, 1'b1, 5'd7, 64'h7, "rstwr");
        check_val("rstwr_r7", reg_of(7), 64'h0);
        step(1'b0, 1'b1, 5'd7, 64'h7, "wr7");
        check_val("wr7_r7", reg_of(7), 64'h7);

        // Reset in the middle of a write burst
        step(1'b0, 1'b1, 5'd1, 64'h11, "burst1");
        step(1'b0, 1'b1, 5'd2, 64'h22, "burst2");
        step(1'b1, 1'b1, 5'd3, 64'h33, "burst_rst");
        step(1'b0, 1'b1, 5'd4, 64'h44, "burst4");
        check_val("burst_r1", reg_of(1), 64'h0);
        check_val("burst_r4", reg_of(4), 64'h44);

        // 6: address sweep with data = addr * 0x0101
        for (int a = 0; a < NUM_REGS; a++) begin
            step(1'b0, 1'b1, ADDR_BITS'(a), 64'(a) * 64'h0101, $sformatf("sweep%0d", a));
        end
        check_val("sweep_r30", reg_of(30), 64'h1E1E);
        check_val("sweep_r31", reg_of(31), 64'h0);

        // Disabled writes with random address/data leave storage alone
        for (int n = 0; n < 40; n++) begin
            step(1'b0, 1'b0, ADDR_BITS'($urandom_range(0, 31)), {$urandom, $urandom}, "noen");
        end

        // Random mixed traffic with occasional resets
        for (int n = 0; n < 300; n++) begin
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
                 ADDR_BITS'($urandom_range(0, 31)), {$urandom, $urandom}, "rnd");
        end

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end
endmodule
